// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: FSM state encoding, request record
// and the round-robin helper.
package bram_arb_pkg;

  localparam int ARB_DATA_W = 16;
  localparam int ARB_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  lock;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  // The port that is preferred after a transfer is the one that did not just win.
  function automatic logic next_rr(input logic [1:0] grant);
    return grant[0];
  endfunction

endpackage

// File: rtl/bram_arb_grant.sv
// Arbitration core: IDLE/LOCK0/LOCK1 FSM, round-robin pointer and one-hot grant decode.
// state | meaning
// IDLE  | no lock held; both ports compete, rr breaks ties
// LOCK0 | port 0 holds the RAM until it sends a beat with lock = 0
// LOCK1 | port 1 holds the RAM until it sends a beat with lock = 0
module bram_arb_grant
  import bram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic [1:0] lock_i,
  output logic [1:0] grant_o
);

  arb_state_t state_q, state_d;
  logic       rr_q, rr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (valid_i == 2'b11) grant_o = rr_q ? 2'b10 : 2'b01;
        else                  grant_o = valid_i;
        if (grant_o != 2'b00) rr_d = next_rr(grant_o);
        if (grant_o[0] && lock_i[0])      state_d = LOCK0;
        else if (grant_o[1] && lock_i[1]) state_d = LOCK1;
      end
      LOCK0: begin
        grant_o = {1'b0, valid_i[0]};
        if (valid_i[0] && !lock_i[0]) begin
          state_d = IDLE;
          rr_d    = next_rr(grant_o);
        end
      end
      LOCK1: begin
        grant_o = {valid_i[1], 1'b0};
        if (valid_i[1] && !lock_i[1]) begin
          state_d = IDLE;
          rr_d    = next_rr(grant_o);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin two-port arbiter in front of a read-first single-port BRAM.
// Define BRAM_ARB_STATS_EN to add saturating grant/conflict statistics counters.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
`ifdef BRAM_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_grant0,
  output logic [CNT_WIDTH-1:0]  stat_grant1,
  output logic [CNT_WIDTH-1:0]  stat_conflict
`endif
);

  logic [1:0] grant;
  logic [1:0] rvalid_q, rvalid_d;

  bram_arb_grant u_grant (
    .clk_i   (clka),
    .rst_i   (rsta),
    .valid_i ({p1_valid, p0_valid}),
    .lock_i  ({p1_lock, p0_lock}),
    .grant_o (grant)
  );

  assign p0_ready = grant[0];
  assign p1_ready = grant[1];

  always_comb begin
    mem_ena   = |grant;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = '0;
    if (grant[0]) begin
      mem_wea   = p0_we;
      mem_addra = p0_addr;
      mem_dina  = p0_wdata;
    end else if (grant[1]) begin
      mem_wea   = p1_we;
      mem_addra = p1_addr;
      mem_dina  = p1_wdata;
    end
  end

  // The RAM registers its output, so a read response trails its grant by one cycle.
  always_comb begin
    rvalid_d[0] = grant[0] && !p0_we;
    rvalid_d[1] = grant[1] && !p1_we;
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) rvalid_q <= 2'b00;
    else      rvalid_q <= rvalid_d;
  end

  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = mem_douta;
  assign p1_rdata  = mem_douta;

`ifdef BRAM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant0_q, grant1_q, conflict_q;
  logic                 conflict;

  assign conflict = (p0_valid && !grant[0]) || (p1_valid && !grant[1]);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (grant[0] && grant0_q != '1)   grant0_q   <= grant0_q + 1'b1;
      if (grant[1] && grant1_q != '1)   grant1_q   <= grant1_q + 1'b1;
      if (conflict && conflict_q != '1) conflict_q <= conflict_q + 1'b1;
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: vector table for grants/mem drive, scoreboard for read data.
module tb_bram_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          p0_valid = 0, p0_we = 0, p0_lock = 0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_valid = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina;
  logic [DW-1:0] mem_douta = '0;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clka = ~clka;

  bram_arbiter dut (
    .clka(clka), .rsta(rsta),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_douta(mem_douta)
`ifdef BRAM_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // Read-first RAM with registered output.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
  always @(posedge clka) begin
    if (mem_ena) begin
      mem_douta <= ram[mem_addra];
      if (mem_wea) ram[mem_addra] <= mem_dina;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: shadow memory predicts read data; entries are due one cycle after acceptance.
  typedef struct { logic port; logic [DW-1:0] data; } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;

  always @(negedge clka) begin
    rd_t e;
    if (rsta) begin
      sb.delete();
      chk("rvalid0_in_reset", {31'b0, p0_rvalid}, 32'd0);
      chk("rvalid1_in_reset", {31'b0, p1_rvalid}, 32'd0);
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rvalid0", {31'b0, p0_rvalid}, {31'b0, !e.port});
        chk("rvalid1", {31'b0, p1_rvalid}, {31'b0, e.port});
        chk("rdata", {16'b0, e.port ? p1_rdata : p0_rdata}, {16'b0, e.data});
      end else begin
        chk("rvalid0_idle", {31'b0, p0_rvalid}, 32'd0);
        chk("rvalid1_idle", {31'b0, p1_rvalid}, 32'd0);
      end
      if (p0_valid && p0_ready) begin
        if (p0_we) shadow[p0_addr] = p0_wdata;
        else sb.push_back('{port: 1'b0, data: shadow[p0_addr]});
      end
      if (p1_valid && p1_ready) begin
        if (p1_we) shadow[p1_addr] = p1_wdata;
        else sb.push_back('{port: 1'b1, data: shadow[p1_addr]});
      end
    end
  end

  typedef struct {
    logic v0, we0, lk0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1, we1, lk1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic er0, er1;
  } vec_t;

  function automatic vec_t mk(input logic v0, we0, lk0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, we1, lk1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic er0, er1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    @(posedge clka); #1;
    p0_valid = v.v0; p0_we = v.we0; p0_lock = v.lk0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_valid = v.v1; p1_we = v.we1; p1_lock = v.lk1; p1_addr = v.a1; p1_wdata = v.d1;
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (v.er0)      begin e_we = v.we0; e_a = v.a0; e_d = v.d0; end
    else if (v.er1) begin e_we = v.we1; e_a = v.a1; e_d = v.d1; end
    @(negedge clka);
    chk({tag, ".ready0"}, {31'b0, p0_ready}, {31'b0, v.er0});
    chk({tag, ".ready1"}, {31'b0, p1_ready}, {31'b0, v.er1});
    chk({tag, ".mem_ena"}, {31'b0, mem_ena}, {31'b0, v.er0 | v.er1});
    chk({tag, ".mem_wea"}, {31'b0, mem_wea}, {31'b0, e_we});
    chk({tag, ".mem_addra"}, {23'b0, mem_addra}, {23'b0, e_a});
    chk({tag, ".mem_dina"}, {16'b0, mem_dina}, {16'b0, e_d});
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  vec_t tbl[$];

  initial begin
    // Basic table: writes, alternating dual reads, write-then-read across ports.
    tbl.push_back(mk(0,0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,0));
    tbl.push_back(mk(1,1,0,9'h010,16'hBEEF, 0,0,0,9'h000,16'h0000, 1,0));
    tbl.push_back(mk(0,0,0,9'h000,16'h0000, 1,1,0,9'h002,16'h2222, 0,1));
    tbl.push_back(mk(1,1,0,9'h001,16'h1111, 0,0,0,9'h000,16'h0000, 1,0));
    tbl.push_back(mk(0,0,0,9'h000,16'h0000, 1,0,0,9'h010,16'h0000, 0,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,9'h001,16'h0000, 1,0,0,9'h002,16'h0000, (i%2)==0, (i%2)==1));
    tbl.push_back(mk(0,0,0,9'h000,16'h0000, 1,1,0,9'h020,16'h1234, 0,1));
    tbl.push_back(mk(1,0,0,9'h020,16'h0000, 0,0,0,9'h000,16'h0000, 1,0));
    tbl.push_back(mk(1,1,0,9'h030,16'hAAAA, 1,1,0,9'h031,16'hBBBB, 0,1));
    tbl.push_back(mk(0,0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,0));

    repeat (3) @(posedge clka);
    @(negedge clka); rsta = 0;
    chk("reset.ready0", {31'b0, p0_ready}, 32'd0);
    chk("reset.mem_ena", {31'b0, mem_ena}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Lock sequence: p0 holds three beats (one idle gap) while p1 waits.
    apply(mk(1,0,1,9'h001,16'h0, 1,0,0,9'h002,16'h0, 1,0), "lockA");
    apply(mk(1,0,1,9'h001,16'h0, 1,0,0,9'h002,16'h0, 1,0), "lockB");
    apply(mk(0,0,0,9'h000,16'h0, 1,0,0,9'h002,16'h0, 0,0), "lockGap");
    apply(mk(1,0,0,9'h001,16'h0, 1,0,0,9'h002,16'h0, 1,0), "lockC");
    apply(mk(1,0,0,9'h001,16'h0, 1,0,0,9'h002,16'h0, 0,1), "lockRelease");

    // Enter LOCK1, then reset right after a read is accepted.
    apply(mk(0,0,0,9'h000,16'h0, 1,0,1,9'h010,16'h0, 0,1), "lock1Enter");
    apply(mk(1,0,0,9'h001,16'h0, 1,0,1,9'h020,16'h0, 0,1), "lock1Read");
    #2 rsta = 1;
    @(posedge clka); #1 idle_inputs();
    repeat (2) @(posedge clka);
    @(negedge clka); rsta = 0;
    // IDLE with rr = 0 after reset: port 0 must win; RAM contents survive.
    apply(mk(1,0,0,9'h010,16'h0, 1,0,0,9'h020,16'h0, 1,0), "postRst0");
    apply(mk(1,0,0,9'h010,16'h0, 1,0,0,9'h020,16'h0, 0,1), "postRst1");
    apply(mk(0,0,0,9'h000,16'h0, 0,0,0,9'h000,16'h0, 0,0), "postRstIdle");

`ifdef BRAM_ARB_STATS_EN
    @(posedge clka); #1 rsta = 1;
    @(negedge clka); rsta = 0;
    chk("stat_grant0_rst", {16'b0, stat_grant0}, 32'd0);
    chk("stat_conflict_rst", {16'b0, stat_conflict}, 32'd0);
    for (int i = 0; i < 10; i++)
      apply(mk(1,0,0,9'h001,16'h0, 1,0,0,9'h002,16'h0, (i%2)==0, (i%2)==1), $sformatf("stats%0d", i));
    apply(mk(0,0,0,9'h000,16'h0, 0,0,0,9'h000,16'h0, 0,0), "statsIdle");
    chk("stat_grant0", {16'b0, stat_grant0}, 32'd5);
    chk("stat_grant1", {16'b0, stat_grant1}, 32'd5);
    chk("stat_conflict", {16'b0, stat_conflict}, 32'd10);
`endif

    repeat (2) @(negedge clka);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
